// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control/config bus and PWM outputs of pwm_multi
interface pwm_multi_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16
);
    logic                  enable;
    logic [WIDTH-1:0]      period;
    logic [N_CH*WIDTH-1:0] duty;
    logic                  center_mode;
    logic [N_CH-1:0]       polarity;
    logic                  load;
    logic                  load_ack;
    logic                  period_tick;
    logic [N_CH-1:0]       pwm_out;

    modport master (
        output enable, period, duty, center_mode, polarity, load,
        input  load_ack, period_tick, pwm_out
    );

    modport slave (
        input  enable, period, duty, center_mode, polarity, load,
        output load_ack, period_tick, pwm_out
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM with shared edge/center counter and double-buffered config
module pwm_multi #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       reset_n,
    pwm_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] one = WIDTH'(1);

    logic [WIDTH-1:0]      stg_period, act_period, eff_period, cnt, cnt_n;
    logic [N_CH*WIDTH-1:0] stg_duty, act_duty, eff_duty;
    logic                  stg_center, act_center, eff_center;
    logic [N_CH-1:0]       stg_pol, act_pol, eff_pol, raw;
    logic                  load_pending, dir_down, dir_down_n;
    logic                  boundary, take_in, take_stg, apply;

    // Boundary detection and the configuration in force this cycle; at a boundary the
    // incoming set is used immediately so the first cycle of the period has no runt.
    always_comb begin
        boundary   = bus.enable && cnt == '0 && !dir_down;
        take_in    = boundary && bus.load;
        take_stg   = boundary && load_pending;
        apply      = take_in || take_stg;
        eff_period = take_in ? bus.period      : take_stg ? stg_period : act_period;
        eff_duty   = take_in ? bus.duty        : take_stg ? stg_duty   : act_duty;
        eff_center = take_in ? bus.center_mode : take_stg ? stg_center : act_center;
        eff_pol    = take_in ? bus.polarity    : take_stg ? stg_pol    : act_pol;
        raw        = '0;
        for (int i = 0; i < N_CH; i++)
            raw[i] = eff_period != '0 && cnt < eff_duty[i*WIDTH +: WIDTH];
    end

    // Next counter value: sawtooth in edge mode, up/down triangle in center mode
    always_comb begin
        cnt_n      = '0;
        dir_down_n = 1'b0;
        if (bus.enable && eff_period != '0) begin
            if (!eff_center) begin
                cnt_n = cnt >= eff_period - one ? '0 : cnt + one;
            end else if (!dir_down) begin
                dir_down_n = cnt >= eff_period - one;
                cnt_n      = dir_down_n ? cnt : cnt + one;
            end else begin
                dir_down_n = cnt != '0;
                cnt_n      = dir_down_n ? cnt - one : cnt;
            end
        end
    end

    // Staging capture and promotion of the staged set to active at a boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_period   <= '0;
            stg_duty     <= '0;
            stg_center   <= 1'b0;
            stg_pol      <= '0;
            act_period   <= '0;
            act_duty     <= '0;
            act_center   <= 1'b0;
            act_pol      <= '0;
            load_pending <= 1'b0;
        end else begin
            if (bus.load) begin
                stg_period <= bus.period;
                stg_duty   <= bus.duty;
                stg_center <= bus.center_mode;
                stg_pol    <= bus.polarity;
            end
            if (apply) begin
                act_period <= eff_period;
                act_duty   <= eff_duty;
                act_center <= eff_center;
                act_pol    <= eff_pol;
            end
            load_pending <= !boundary && (load_pending || bus.load);
        end
    end

    // Shared period counter and direction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            dir_down <= dir_down_n;
        end
    end

    // Registered outputs: polarity-adjusted PWM, period tick and load acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pwm_out     <= '0;
            bus.period_tick <= 1'b0;
            bus.load_ack    <= 1'b0;
        end else begin
            bus.pwm_out     <= bus.enable ? raw ^ eff_pol : act_pol;
            bus.period_tick <= boundary && eff_period != '0;
            bus.load_ack    <= apply;
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi against a period-level model
module tb_pwm_multi;
    typedef struct packed {
        logic [15:0]       p;
        logic [3:0][15:0]  d;
        logic              c;
        logic [3:0]        pol;
    } cfg_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    pwm_multi_if #(.N_CH(4), .WIDTH(16)) bus();
    pwm_multi #(.N_CH(4), .WIDTH(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    cfg_t       stg, act, cur;
    bit         pend;
    int         phase;
    logic [3:0] exp_out;
    logic       exp_tick, exp_ack;
    int         hc[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stg = '0; act = '0; pend = 0; phase = 0;
    endtask

    // One clock of the reference: period-relative position, not the counter value
    task automatic model_step(input bit en, input bit ld, input cfg_t c);
        int len, m, pp, dd;
        exp_ack = 0;
        exp_tick = 0;
        if (!en) begin
            phase = 0;
            if (ld) begin stg = c; pend = 1; end
            exp_out = act.pol;
            return;
        end
        if (phase == 0 && (ld || pend)) begin
            act = ld ? c : stg;
            if (ld) stg = c;
            pend = 0;
            exp_ack = 1;
        end else if (ld) begin
            stg = c;
            pend = 1;
        end
        pp = int'(act.p);
        if (pp == 0) begin
            exp_out = act.pol;
            return;
        end
        len = act.c ? 2 * pp : pp;
        for (int i = 0; i < 4; i++) begin
            dd = int'(act.d[i]);
            m = dd < pp ? dd : pp;
            exp_out[i] = ((phase < m) || (act.c && phase >= len - m)) ^ act.pol[i];
        end
        exp_tick = phase == 0;
        phase = (phase + 1) % len;
    endtask

    task automatic step(input bit en, input bit ld, input cfg_t c);
        bus.enable = en; bus.load = ld; bus.period = c.p; bus.duty = c.d;
        bus.center_mode = c.c; bus.polarity = c.pol;
        model_step(en, ld, c);
        @(posedge clk); #1;
        check("pwm_out", 32'(bus.pwm_out), 32'(exp_out));
        check("period_tick", 32'(bus.period_tick), 32'(exp_tick));
        check("load_ack", 32'(bus.load_ack), 32'(exp_ack));
    endtask

    // Count high samples per channel over n cycles starting at the next period_tick
    task automatic measure(input int n);
        int got = 0;
        bit seen = 0;
        hc = '{default: 0};
        for (int k = 0; k < 400 && got < n; k++) begin
            step(1, 0, cur);
            if (bus.period_tick) seen = 1;
            if (seen) begin
                for (int i = 0; i < 4; i++) hc[i] += int'(bus.pwm_out[i]);
                got++;
            end
        end
        check("measure_len", got, n);
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.p = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
        for (int i = 0; i < 4; i++) c.d[i] = 16'($urandom_range(0, 14));
        c.c = 1'($urandom_range(0, 1));
        c.pol = 4'($urandom_range(0, 15));
        return c;
    endfunction

    initial begin
        cur = '0;
        bus.enable = 0; bus.load = 0; bus.period = '0; bus.duty = '0;
        bus.center_mode = 0; bus.polarity = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(bus.pwm_out), 0);
        check("rst_tick", 32'(bus.period_tick), 0);
        check("rst_ack", 32'(bus.load_ack), 0);
        reset_n = 1;

        cur = '0; cur.p = 100; cur.d[0] = 0; cur.d[1] = 50; cur.d[2] = 100; cur.d[3] = 150;
        step(1, 1, cur);
        measure(100);
        check("p1_hi0", hc[0], 0);
        check("p1_hi1", hc[1], 50);
        check("p1_hi2", hc[2], 100);
        check("p1_hi3", hc[3], 100);
        step(1, 0, cur);
        check("p1_tick_rep", 32'(bus.period_tick), 1);

        cur.d[0] = 50;
        step(1, 1, cur);
        repeat (130) step(1, 0, cur);
        cur.d[0] = 20;
        step(1, 1, cur);
        repeat (250) step(1, 0, cur);

        cur = '0; cur.p = 10; cur.d[0] = 3; cur.c = 1;
        step(1, 1, cur);
        measure(20);
        check("p3_center_hi", hc[0], 6);
        repeat (45) step(1, 0, cur);

        cur = '0; cur.p = 100; cur.d[0] = 25; cur.pol = 4'b0001;
        step(1, 1, cur);
        measure(100);
        check("p4_pol_hi", hc[0], 75);
        step(0, 0, cur);
        step(0, 0, cur);
        check("p4_idle_level", 32'(bus.pwm_out[0]), 1);

        cur = '0; cur.d[1] = 5;
        step(0, 1, cur);
        repeat (30) step(1, 0, cur);

        cur = '0; cur.p = 50; cur.d = {16'd7, 16'd13, 16'd40, 16'd2};
        step(1, 1, cur);
        repeat (10) step(1, 0, cur);
        cur.d[0] = 30; cur.c = 1;
        step(1, 1, cur);
        step(1, 0, cur);
        cur.d[0] = 9; cur.pol = 4'b1010;
        step(1, 1, cur);
        repeat (200) step(1, 0, cur);

        cur = '0; cur.p = 20; cur.d = {4{16'd20}};
        step(1, 1, cur);
        repeat (13) step(1, 0, cur);
        #2 reset_n = 0;
        #1 check("async_rst_out", 32'(bus.pwm_out), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        model_reset();
        repeat (20) step(1, 0, cur);

        for (int n = 0; n < 2500; n++) begin
            bit en = $urandom_range(0, 29) != 0;
            bit ld = $urandom_range(0, 9) == 0;
            if (ld) cur = rand_cfg();
            step(en, ld, ld ? cur : rand_cfg());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
